// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron accumulate-and-threshold stage.
package perceptron_pkg;

  localparam int PSUM_W_DEF    = 7;
  localparam int ACC_W_DEF     = 12;
  localparam int MAX_BEATS_DEF = 32;
  localparam int CNT_W_DEF     = $clog2(MAX_BEATS_DEF + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/perceptron_accumulator_if.sv
// Partial-sum input channel and decision output channel of the accumulator.
interface perceptron_accumulator_if
  import perceptron_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum;
  logic              psum_last;
  logic [ACC_W-1:0]  threshold;
  logic              out_valid;
  logic              out_ready;
  logic              out_fire;
  logic [ACC_W-1:0]  out_sum;
  logic              out_err;

  modport master (
    output psum_valid, psum, psum_last, threshold, out_ready,
    input  psum_ready, out_valid, out_fire, out_sum, out_err
  );

  modport slave (
    input  psum_valid, psum, psum_last, threshold, out_ready,
    output psum_ready, out_valid, out_fire, out_sum, out_err
  );

endinterface

// File: rtl/perceptron_accumulator_sat_add.sv
// Unsigned W-bit adder that clamps to all-ones and flags the carry-out.
module sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  logic [W:0] raw;

  assign raw   = {1'b0, a_i} + {1'b0, b_i};
  assign sat_o = raw[W];
  assign sum_o = raw[W] ? '1 : raw[W-1:0];

endmodule

// File: rtl/perceptron_accumulator.sv
// Accumulates tree partial sums per feature vector and emits a registered
// fire/no-fire decision over a valid/ready handshake.
//
//   state | meaning
//   ACCUM | no result held; awaiting or accumulating a vector
//   HOLD  | decision held on the output until popped
module perceptron_accumulator
  import perceptron_pkg::*;
#(
  parameter int PSUM_W    = PSUM_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  perceptron_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  acc_state_t       state_q, state_d;
  logic             first_q, first_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fire_q, fire_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             oerr_q, oerr_d;

  logic             accept;
  logic             pop;
  logic             forced;
  logic             term;
  logic             sat;
  logic             err_next;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic [ACC_W-1:0] thr_eff;
  logic [CNT_W-1:0] cnt_next;

  assign bus.psum_ready = (state_q == ACCUM) || bus.out_ready;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_fire   = fire_q;
  assign bus.out_sum    = sum_q;
  assign bus.out_err    = oerr_q;

  assign accept = bus.psum_valid && bus.psum_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  // On the first beat the adder sees zero, so the beat simply loads the accumulator.
  assign add_a = first_q ? '0 : acc_q;
  assign add_b = {{(ACC_W - PSUM_W){1'b0}}, bus.psum};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum),
    .sat_o (sat)
  );

  assign cnt_next = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
  // A vector closed by psum_last on its final allowed beat is a normal end.
  assign forced   = (cnt_next == CNT_W'(MAX_BEATS)) && !bus.psum_last;
  assign term     = accept && (bus.psum_last || forced);
  assign err_next = (first_q ? 1'b0 : err_q) | sat | forced;
  assign thr_eff  = first_q ? bus.threshold : thr_q;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fire_d  = fire_q;
    sum_d   = sum_q;
    oerr_d  = oerr_q;

    case (state_q)
      ACCUM:   if (term) state_d = HOLD;
      HOLD:    if (pop && !term) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (accept) begin
      acc_d   = add_sum;
      thr_d   = thr_eff;
      cnt_d   = cnt_next;
      err_d   = err_next;
      first_d = term;
    end

    if (term) begin
      sum_d  = add_sum;
      fire_d = (add_sum >= thr_eff);
      oerr_d = err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      first_q <= 1'b1;
      acc_q   <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fire_q  <= 1'b0;
      sum_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fire_q  <= fire_d;
      sum_q   <= sum_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: tb/tb_perceptron_accumulator.sv
// Bench for perceptron_accumulator: directed cases plus randomized vectors
// against a per-vector arithmetic reference.
module tb_perceptron_accumulator;

  localparam int MAXA = 32;

  typedef struct {
    int sum;
    bit fire;
    bit err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  perceptron_accumulator_if #(.PSUM_W(7), .ACC_W(12)) ifa ();
  perceptron_accumulator_if #(.PSUM_W(7), .ACC_W(8))  ifb ();

  perceptron_accumulator #(.PSUM_W(7), .ACC_W(12), .MAX_BEATS(MAXA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  perceptron_accumulator #(.PSUM_W(7), .ACC_W(8), .MAX_BEATS(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole-vector reference: total of all beats, clamped; errors from clamp or overrun.
  function automatic res_t model(input int beats[$], input bit use_last, input int thr,
                                 input int accw, input int maxb);
    longint total = 0;
    int     maxv  = (1 << accw) - 1;
    res_t   r;
    foreach (beats[i]) total += beats[i];
    r.sum  = (total > maxv) ? maxv : int'(total);
    r.err  = (total > maxv) || (!use_last && beats.size() == maxb);
    r.fire = (r.sum >= thr);
    return r;
  endfunction

  task automatic tick_a(output bit acc);
    @(negedge clk);
    acc = ifa.psum_valid && ifa.psum_ready;
    check("a_ready_rule", ifa.psum_ready, !ifa.out_valid || ifa.out_ready);
    if (ifa.out_valid) begin
      check("a_result_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("a_out_sum", ifa.out_sum, exp_q[0].sum);
        check("a_out_fire", ifa.out_fire, exp_q[0].fire);
        check("a_out_err", ifa.out_err, exp_q[0].err);
        if (ifa.out_ready) void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int beats[$], input bit use_last, input int thr, input int rmode);
    bit acc;
    int budget;
    for (int i = 0; i < beats.size(); i++) begin
      ifa.psum_valid = 1'b1;
      ifa.psum       = 7'(beats[i]);
      ifa.psum_last  = use_last && (i == beats.size() - 1);
      ifa.threshold  = (i == 0) ? 12'(thr) : 12'($urandom_range(0, 4095));
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 64) begin
        ifa.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        tick_a(acc);
        budget++;
      end
      check("a_beat_accept_bound", acc, 1);
    end
    ifa.psum_valid = 1'b0;
    ifa.psum_last  = 1'b0;
    if (use_last || beats.size() == MAXA) begin
      check("a_result_latency", ifa.out_valid, 1);
      exp_q.push_back(model(beats, use_last, thr, 12, MAXA));
    end
  endtask

  task automatic drain_a();
    bit acc;
    ifa.psum_valid = 1'b0;
    ifa.out_ready  = 1'b1;
    for (int i = 0; i < 8 && (exp_q.size() != 0 || ifa.out_valid); i++) tick_a(acc);
    check("a_drained", exp_q.size(), 0);
    check("a_idle_valid", ifa.out_valid, 0);
  endtask

  task automatic beat_b(input int p, input bit last, input int thr);
    ifb.psum_valid = 1'b1;
    ifb.psum       = 7'(p);
    ifb.psum_last  = last;
    ifb.threshold  = 8'(thr);
    @(negedge clk);
    check("b_ready", ifb.psum_ready, 1);
    @(posedge clk);
    #1;
    ifb.psum_valid = 1'b0;
    ifb.psum_last  = 1'b0;
  endtask

  task automatic check_b(input string tag, input int vld, input int sum, input int fire, input int err);
    check({tag, "_valid"}, ifb.out_valid, vld);
    check({tag, "_sum"}, ifb.out_sum, sum);
    check({tag, "_fire"}, ifb.out_fire, fire);
    check({tag, "_err"}, ifb.out_err, err);
  endtask

  initial begin
    int  v[$];
    int  len;
    int  thr;
    bit  use_last;
    bit  acc;

    rst_n          = 1'b0;
    ifa.psum_valid = 1'b0;
    ifa.psum       = '0;
    ifa.psum_last  = 1'b0;
    ifa.threshold  = '0;
    ifa.out_ready  = 1'b1;
    ifb.psum_valid = 1'b0;
    ifb.psum       = '0;
    ifb.psum_last  = 1'b0;
    ifb.threshold  = '0;
    ifb.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", ifa.out_valid, 0);
    check("rst_a_sum", ifa.out_sum, 0);
    check("rst_a_fire", ifa.out_fire, 0);
    check("rst_a_err", ifa.out_err, 0);
    check("rst_a_ready", ifa.psum_ready, 1);
    check("rst_b_valid", ifb.out_valid, 0);
    check("rst_b_ready", ifb.psum_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic vectors at threshold 100 and 102.
    v = {40, 30, 31};
    send_a(v, 1'b1, 100, 0);
    check("d1_sum", ifa.out_sum, 101);
    check("d1_fire", ifa.out_fire, 1);
    check("d1_err", ifa.out_err, 0);
    send_a(v, 1'b1, 102, 0);
    check("d2_sum", ifa.out_sum, 101);
    check("d2_fire", ifa.out_fire, 0);
    drain_a();

    // Backpressure: result held, next vector stalls, then pop and accept together.
    send_a(v, 1'b1, 100, 0);
    ifa.out_ready  = 1'b0;
    ifa.psum_valid = 1'b1;
    ifa.psum       = 7'd5;
    ifa.psum_last  = 1'b0;
    ifa.threshold  = 12'd10;
    repeat (4) begin
      tick_a(acc);
      check("bp_stall_ready", ifa.psum_ready, 0);
      check("bp_no_accept", acc, 0);
    end
    v = {5, 6};
    send_a(v, 1'b1, 10, 0);
    check("bp_second_sum", ifa.out_sum, 11);
    check("bp_second_fire", ifa.out_fire, 1);
    drain_a();

    // Reset with a result held drops out_valid at once.
    v = {50};
    send_a(v, 1'b1, 0, 0);
    ifa.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", ifa.out_valid, 0);
    check("rst_hold_sum", ifa.out_sum, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-vector discards the partial accumulation.
    v = {20, 20};
    send_a(v, 1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", ifa.out_valid, 0);
    check("rst_mid_sum", ifa.out_sum, 0);
    check("rst_mid_fire", ifa.out_fire, 0);
    check("rst_mid_err", ifa.out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = {7};
    send_a(v, 1'b1, 7, 0);
    check("post_rst_sum", ifa.out_sum, 7);
    check("post_rst_fire", ifa.out_fire, 1);
    check("post_rst_err", ifa.out_err, 0);
    drain_a();

    // Saturation on the narrow instance.
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat_b(84, i == 3, 200);
    check_b("sat", 1, 255, 1, 1);
    @(posedge clk);
    #1;
    check("sat_popped", ifb.out_valid, 0);

    // Forced termination after four beats; the fifth opens a new vector.
    for (int i = 0; i < 4; i++) beat_b(10, 1'b0, 30);
    check_b("force", 1, 40, 1, 1);
    beat_b(10, 1'b0, 12);
    check("force_next_popped", ifb.out_valid, 0);
    beat_b(5, 1'b1, 100);
    check_b("force_next", 1, 15, 1, 0);

    // Randomized vectors with random backpressure and idle gaps.
    for (int n = 0; n < 40; n++) begin
      v.delete();
      if ($urandom_range(0, 7) == 0) begin
        len      = MAXA;
        use_last = 1'b0;
      end else begin
        len      = $urandom_range(1, 12);
        use_last = 1'b1;
      end
      for (int i = 0; i < len; i++) v.push_back($urandom_range(0, 127));
      thr = $urandom_range(0, 1200);
      send_a(v, use_last, thr, $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        ifa.out_ready = 1'($urandom_range(0, 1));
        tick_a(acc);
      end
    end
    drain_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_accumulator.md
# perceptron_accumulator

Sequential accumulate-and-threshold stage placed directly after the 12-operand Wallace reduction tree in the perceptron datapath. It consumes one 7-bit partial sum per beat, with up to 12 weighted inputs per beat. It accumulates beats until the end of a feature vector and compares the total against a threshold. It then presents a registered fire/no-fire decision with the full sum to the training/control logic through a valid/ready handshake.

## Interface
Parameters:
- PSUM_W, 7, width of the incoming partial sum (matches tree output).
- ACC_W, 12, accumulator and threshold width.
- MAX_BEATS, 32, maximum beats per vector before forced termination.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- psum_valid  in  1  partial sum present.
- psum_ready  out  1  block accepts a beat this cycle.
- psum  in  PSUM_W  unsigned partial sum from the tree.
- psum_last  in  1  final beat of the current vector.
- threshold  in  ACC_W  unsigned firing threshold, sampled on the first beat of a vector.
- out_valid  out  1  decision held and valid.
- out_ready  in  1  downstream accepts the decision.
- out_fire  out  1  1 when sum >= threshold.
- out_sum  out  ACC_W  final (possibly saturated) sum.
- out_err  out  1  saturation occurred or MAX_BEATS forced termination.

## Operation
- Beat accepted when psum_valid && psum_ready.
- psum_ready = !out_valid || out_ready: a result being popped frees the stage in the same cycle.
- First beat of a vector (first flag set):
  - acc <= zero-extended psum.
  - thr_q <= threshold.
  - beat_cnt <= 1.
  - err clears.
- Later beats:
  - acc <= acc + psum, saturating at 2^ACC_W-1.
  - Saturation sets sticky err.
- Vector terminates on psum_last, or when the accepted beat makes beat_cnt == MAX_BEATS.
  - A forced termination sets err.
  - Beats after a forced termination start a new vector.
- On termination:
  - out_sum <= final acc value including the current beat.
  - out_fire <= (final sum >= thr_q), or (final sum >= threshold) if this is a single-beat vector.
  - out_err <= err including the current beat.
  - out_valid <= 1.
  - first <= 1.
- Output pop (out_valid && out_ready) clears out_valid unless a terminating beat is accepted in the same cycle. That beat's result is loaded and out_valid stays 1.
- State machine, two states:
  - ACCUM: first=1 or mid-vector.
  - HOLD: out_valid=1 and no new beat being accepted.
  - ACCUM→ACCUM on a non-terminating beat.
  - ACCUM→HOLD on a terminating beat.
  - HOLD→ACCUM on pop without a terminating beat.
  - Accumulation of the next vector may proceed while a result is held.
- out_fire, out_sum and out_err are stable while out_valid=1 and out_ready=0.
- Arithmetic is unsigned throughout. psum is zero-extended to ACC_W+1 for the add; the carry bit signals saturation.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_fire=0, out_sum=0, out_err=0; psum_ready=1 after reset.
  - Internal: acc=0, beat_cnt=0, first=1, thr_q=0.
- Reset asserted mid-vector discards partial state with no result emitted. Reset asserted with a held result drops out_valid immediately (asynchronous).
- Latency: result is valid the cycle after the terminating beat is accepted.
- Throughput: one beat per cycle sustained. No bubble between vectors when out_ready=1.
- Backpressure:
  - With out_valid=1 and out_ready=0, psum_ready=0.
  - Beats of the next vector are stalled, not dropped.

## Structure
- Shared package perceptron_pkg:
  - PSUM_W/ACC_W/MAX_BEATS defaults.
  - Two-state enum acc_state_t {ACCUM, HOLD}.
  - Beat-counter width, $clog2(MAX_BEATS+1).
- One sub-module, sat_add: a combinational ACC_W saturating adder with a saturation flag. Everything else is flat in perceptron_accumulator.

## Test plan
- Single vector, out_ready=1, threshold=100: beats 40,30,31 (last on 31) → one cycle later out_valid=1, out_sum=101, out_fire=1, out_err=0.
- Same beats with threshold=102 → out_sum=101, out_fire=0.
- Saturation with ACC_W=8, threshold=200: beats 84,84,84,84 last → out_sum=255, out_err=1, out_fire=1.
- Forced termination with MAX_BEATS=4: five beats of 10, no psum_last → first result out_sum=40, out_err=1. The fifth beat starts a new vector.
- Backpressure: hold out_ready=0 after a result and drive the next vector → psum_ready=0, outputs stable. Release out_ready → pop and accept occur in the same cycle, and the second result appears correctly.
- Reset mid-vector: after two beats, pulse rst_n low asynchronously → all outputs 0 immediately. The next vector of a single beat 7 with last, threshold=7 → out_sum=7, out_fire=1.
